// File: rtl/stretch.sv
// Pulse stretcher: delays `in` by DELAY_TICKS cycles, then holds `out` high for
// up to MAX_LENGTH_TICKS extra cycles after the delayed input falls.
module stretch #(
  parameter int MAX_LENGTH_TICKS = 100,
  parameter int DELAY_TICKS      = 100,
  localparam int W               = $clog2(MAX_LENGTH_TICKS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in,
  input  logic [W-1:0] strch,
  output logic         out
);

  localparam logic [W-1:0] MAX_W = W'(MAX_LENGTH_TICKS);

  logic         dly;
  logic [W-1:0] eff;
  logic [W-1:0] cnt;

  // Delay line: one bit per cycle of delay, so every short pulse or gap survives.
  generate
    if (DELAY_TICKS == 0) begin : g_nodly
      assign dly = in;
    end else if (DELAY_TICKS == 1) begin : g_dly1
      logic sr;
      always_ff @(posedge clk) begin
        if (!rst) sr <= 1'b0;
        else      sr <= in;
      end
      assign dly = sr;
    end else begin : g_dlyn
      logic [DELAY_TICKS-1:0] sr;
      always_ff @(posedge clk) begin
        if (!rst) sr <= '0;
        else      sr <= {sr[DELAY_TICKS-2:0], in};
      end
      assign dly = sr[DELAY_TICKS-1];
    end
  endgenerate

  assign eff = (strch > MAX_W) ? MAX_W : strch;

  // Reloading on every dly-high edge makes the tail restart from the last fall,
  // which is what merges closely spaced runs without a glitch.
  always_ff @(posedge clk) begin
    if (!rst)            cnt <= '0;
    else if (dly)        cnt <= eff;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign out = dly | (cnt != '0);

endmodule

// File: tb/tb_stretch.sv
// Directed bench for stretch: three instances (default, clamped length, zero delay),
// out traces recorded per cycle and runs compared against hand-computed positions.
module tb_stretch;

  localparam int NT = 4096;

  logic       clk;
  logic       rst;
  logic       in_a, in_b, in_c;
  logic [6:0] strch_a;
  logic [5:0] strch_b;
  logic [2:0] strch_c;
  logic       out_a, out_b, out_c;

  int cyc;
  int n_checks;
  int n_errors;

  logic tr_a [NT];
  logic tr_b [NT];
  logic tr_c [NT];

  stretch u_a (.clk(clk), .rst(rst), .in(in_a), .strch(strch_a), .out(out_a));

  stretch #(.MAX_LENGTH_TICKS(50), .DELAY_TICKS(3)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .strch(strch_b), .out(out_b)
  );

  stretch #(.MAX_LENGTH_TICKS(7), .DELAY_TICKS(0)) u_c (
    .clk(clk), .rst(rst), .in(in_c), .strch(strch_c), .out(out_c)
  );

  // Clock and cycle index: cycle t is the period following the t-th rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < NT) begin
      tr_a[cyc] = out_a;
      tr_b[cyc] = out_b;
      tr_c[cyc] = out_c;
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // First run in [from,to): its start cycle and length, plus total number of runs.
  task automatic measure(input int which, input int from, input int to,
                         output int start, output int len, output int runs);
    logic prev, cur;
    start = -1;
    len   = 0;
    runs  = 0;
    prev  = 1'b0;
    for (int t = from; t < to; t++) begin
      cur = (which == 0) ? tr_a[t] : (which == 1) ? tr_b[t] : tr_c[t];
      if (cur === 1'b1 && prev !== 1'b1) begin
        runs++;
        if (runs == 1) start = t;
      end
      if (cur === 1'b1 && runs == 1) len++;
      prev = cur;
    end
  endtask

  int rel, rel2, t1, t2, t3, t4, t5, tb1, tb2, tb3, tc1, tc2, tc3, t_end;
  int st, ln, rn;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    in_a = 1'b0; in_b = 1'b0; in_c = 1'b0;
    strch_a = 7'd40; strch_b = 6'd0; strch_c = 3'd3;

    // Reset held 75 cycles with input activity that must never reach out.
    adv(1);
    in_a = 1'b1; adv(30);
    in_a = 1'b0; adv(44);
    rst = 1'b1; rel = cyc;

    // Two pulses: 50 cycles, then 25 cycles after a 150-cycle gap.
    adv(25);
    in_a = 1'b1; t1 = cyc; adv(50);
    in_a = 1'b0; adv(150);
    in_a = 1'b1; t2 = cyc; adv(25);
    in_a = 1'b0; adv(250);
    t_end = cyc;

    measure(0, 1, rel, st, ln, rn);
    chk("reset_quiet_runs", rn, 0);
    measure(0, rel, t1 + 100, st, ln, rn);
    chk("post_release_quiet_runs", rn, 0);
    measure(0, t1, t2, st, ln, rn);
    chk("p50_start", st, t1 + 100);
    chk("p50_len", ln, 90);
    chk("p50_runs", rn, 1);
    measure(0, t2, t_end, st, ln, rn);
    chk("p25_start", st, t2 + 100);
    chk("p25_len", ln, 65);
    chk("p25_runs", rn, 1);

    // strch = 0: pure delay.
    strch_a = 7'd0;
    in_a = 1'b1; t3 = cyc; adv(10);
    in_a = 1'b0; adv(150);
    measure(0, t3, cyc, st, ln, rn);
    chk("nostretch_start", st, t3 + 100);
    chk("nostretch_len", ln, 10);
    chk("nostretch_runs", rn, 1);

    // Two 5-cycle pulses 20 cycles apart merge into one 70-cycle run.
    strch_a = 7'd40;
    in_a = 1'b1; t4 = cyc; adv(5);
    in_a = 1'b0; adv(20);
    in_a = 1'b1; adv(5);
    in_a = 1'b0; adv(200);
    measure(0, t4, cyc, st, ln, rn);
    chk("merge_start", st, t4 + 100);
    chk("merge_len", ln, 70);
    chk("merge_runs", rn, 1);

    // Reset in the middle of the tail, with in high during reset.
    in_a = 1'b1; t5 = cyc; adv(10);
    in_a = 1'b0; adv(110);
    rst = 1'b0; in_a = 1'b1; adv(5);
    rst = 1'b1; in_a = 1'b0; rel2 = cyc; adv(200);
    measure(0, t5, t5 + 121, st, ln, rn);
    chk("midtail_start", st, t5 + 100);
    chk("midtail_len_cut", ln, 21);
    chk("midtail_first_reset_cycle", int'(tr_a[t5 + 121]), 0);
    measure(0, t5 + 121, cyc, st, ln, rn);
    chk("midtail_after_reset_runs", rn, 0);
    chk("midtail_release_window", cyc - rel2, 200);

    // Clamped length: strch 63 against a 50-cycle maximum.
    strch_b = 6'd63;
    in_b = 1'b1; tb1 = cyc; adv(1);
    in_b = 1'b0; adv(80);
    measure(1, tb1, cyc, st, ln, rn);
    chk("clamp_start", st, tb1 + 3);
    chk("clamp_len", ln, 51);
    chk("clamp_runs", rn, 1);

    strch_b = 6'd5;
    in_b = 1'b1; tb2 = cyc; adv(1);
    in_b = 1'b0; adv(20);
    measure(1, tb2, cyc, st, ln, rn);
    chk("single_pulse_len", ln, 6);
    chk("single_pulse_start", st, tb2 + 3);

    // strch changed on the last dly-high cycle sets the tail length.
    strch_b = 6'd20;
    in_b = 1'b1; tb3 = cyc; adv(4);
    in_b = 1'b0; adv(2);
    strch_b = 6'd2; adv(40);
    measure(1, tb3, cyc, st, ln, rn);
    chk("late_strch_start", st, tb3 + 3);
    chk("late_strch_len", ln, 6);

    // Zero delay: out follows in combinationally, then the tail.
    in_c = 1'b1; tc1 = cyc; adv(2);
    in_c = 1'b0; adv(20);
    measure(2, tc1, cyc, st, ln, rn);
    chk("d0_start", st, tc1);
    chk("d0_len", ln, 5);

    // Gap equal to the tail merges; one cycle longer splits.
    in_c = 1'b1; tc2 = cyc; adv(1);
    in_c = 1'b0; adv(3);
    in_c = 1'b1; adv(1);
    in_c = 1'b0; adv(20);
    measure(2, tc2, cyc, st, ln, rn);
    chk("gap_eq_len", ln, 8);
    chk("gap_eq_runs", rn, 1);

    in_c = 1'b1; tc3 = cyc; adv(1);
    in_c = 1'b0; adv(4);
    in_c = 1'b1; adv(1);
    in_c = 1'b0; adv(20);
    measure(2, tc3, cyc, st, ln, rn);
    chk("gap_gt_len", ln, 4);
    chk("gap_gt_runs", rn, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
